ctr_incr_scheduler: RTL

- Sequencer for the counter-cell increment chain.
- Latches per-counter plus/minus increment requests from peripheral inputs (gyro, radar, magnetometer, uplink), and cancels opposing pairs.
- When the CPU offers a counter slot, grants the highest-priority pending counter for one memory cycle.
- Drives the counter address (CAD), the increment type (PINC/MINC) and the in-cycle flag (INKL) to the counter datapath.

---
 rtl/ctr_incr_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ctr_incr_scheduler.sv
// Counter-cell increment scheduler: latches plus/minus requests per counter
// channel, cancels opposing pairs and grants one counter memory cycle per SLOT.
//
// state | meaning
// IDLE  | no counter cycle active; waiting for SLOT with a request pending
// EXEC  | counter cycle in progress; CAD/PINC/MINC held, cycle timer running
module ctr_incr_scheduler #(
  parameter int         NCTR      = 20,
  parameter logic [5:0] ADDR_BASE = 6'o24,
  parameter int         CYCLE_LEN = 12
) (
  input  logic            CLOCK,
  input  logic            rst,
  input  logic [NCTR-1:0] UP_REQ,
  input  logic [NCTR-1:0] DN_REQ,
  input  logic            SLOT,
  input  logic            MNHNC,
  input  logic            GOJAM,
  output logic            CTROR,
  output logic            INKL,
  output logic [5:0]      CAD,
  output logic            PINC,
  output logic            MINC,
  output logic            DONE
);

  localparam int CW = (CYCLE_LEN > 2) ? $clog2(CYCLE_LEN) : 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state, state_nxt;
  logic [NCTR-1:0] upp, dnp, upp_nxt, dnp_nxt;
  logic [NCTR-1:0] grant_mask, up_v, dn_v;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [5:0]      sel_idx, cad_nxt;
  logic            sel_vld, sel_up, sel_dn;
  logic            inkl_nxt, pinc_nxt, minc_nxt, done_nxt, grant;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    sel_up  = 1'b0;
    sel_dn  = 1'b0;
    for (int i = NCTR - 1; i >= 0; i--) begin
      if (upp[i] | dnp[i]) begin
        sel_idx = 6'(i);
        sel_vld = 1'b1;
        sel_up  = upp[i];
        sel_dn  = dnp[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inkl_nxt  = INKL;
    pinc_nxt  = PINC;
    minc_nxt  = MINC;
    cad_nxt   = CAD;
    done_nxt  = 1'b0;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (SLOT && CTROR && !MNHNC && sel_vld) begin
          grant     = 1'b1;
          state_nxt = EXEC;
          cnt_nxt   = CW'(CYCLE_LEN - 1);
          inkl_nxt  = 1'b1;
          cad_nxt   = ADDR_BASE + sel_idx;
          pinc_nxt  = sel_up;
          minc_nxt  = sel_dn;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          inkl_nxt  = 1'b0;
          pinc_nxt  = 1'b0;
          minc_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (GOJAM) begin
      grant     = 1'b0;
      state_nxt = IDLE;
      inkl_nxt  = 1'b0;
      pinc_nxt  = 1'b0;
      minc_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  // The granted bit is cleared before new requests are merged, so a request
  // landing on the grant edge survives as fresh pending work.
  always_comb begin
    grant_mask = '0;
    if (grant) grant_mask = {{(NCTR-1){1'b0}}, 1'b1} << sel_idx;
    up_v    = (upp & ~grant_mask) | UP_REQ;
    dn_v    = (dnp & ~grant_mask) | DN_REQ;
    upp_nxt = GOJAM ? '0 : (up_v & ~dn_v);
    dnp_nxt = GOJAM ? '0 : (dn_v & ~up_v);
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      upp   <= '0;
      dnp   <= '0;
      CTROR <= 1'b0;
      INKL  <= 1'b0;
      CAD   <= '0;
      PINC  <= 1'b0;
      MINC  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      upp   <= upp_nxt;
      dnp   <= dnp_nxt;
      CTROR <= |(upp_nxt | dnp_nxt);
      INKL  <= inkl_nxt;
      CAD   <= cad_nxt;
      PINC  <= pinc_nxt;
      MINC  <= minc_nxt;
      DONE  <= done_nxt;
    end
  end

endmodule
